// File: rtl/ibex_pkg.sv
// rtl/ibex_pkg.sv - shared types for the register-file write-port scheduler
package ibex_pkg;

  localparam int RfAddrW = 5;

  typedef enum logic [1:0] {
    WPORT_NONE = 2'd0,
    WPORT_LSU  = 2'd1,
    WPORT_ID   = 2'd2,
    WPORT_AUX  = 2'd3
  } wport_src_e;

endpackage

// File: rtl/ibex_rf_wport_fifo.sv
// rtl/ibex_rf_wport_fifo.sv - buffer of pending aux RF writes
// Exposes every entry's address so the scheduler can flag RAW hazards.
module ibex_rf_wport_fifo import ibex_pkg::*; #(
  parameter int Depth = 2,
  parameter int DataW = 32
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       flush_i,
  input  logic                       push_i,
  input  logic [RfAddrW-1:0]         push_waddr_i,
  input  logic [DataW-1:0]           push_wdata_i,
  input  logic                       pop_i,
  output logic [RfAddrW-1:0]         head_waddr_o,
  output logic [DataW-1:0]           head_wdata_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [Depth-1:0]           entry_valid_o,
  output logic [Depth*RfAddrW-1:0]   entry_waddr_o
);

  localparam int PtrW = $clog2(Depth);
  localparam int CntW = $clog2(Depth + 1);

  logic [RfAddrW-1:0] waddr_q [Depth];
  logic [DataW-1:0]   wdata_q [Depth];
  logic [PtrW-1:0]    wptr_q, rptr_q;
  logic [CntW-1:0]    cnt_q;
  logic               do_push, do_pop;

  assign full_o  = (cnt_q == CntW'(Depth));
  assign empty_o = (cnt_q == '0);
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  assign head_waddr_o = waddr_q[rptr_q];
  assign head_wdata_o = wdata_q[rptr_q];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else if (flush_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + 1'b1;
      if (do_pop)  rptr_q <= rptr_q + 1'b1;
      cnt_q <= cnt_q + CntW'(do_push) - CntW'(do_pop);
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push && !flush_i) begin
      waddr_q[wptr_q] <= push_waddr_i;
      wdata_q[wptr_q] <= push_wdata_i;
    end
  end

  // Entry i is live when its distance from the read pointer is below the count.
  for (genvar i = 0; i < Depth; i++) begin : g_ent
    logic [PtrW-1:0] off;
    assign off                                  = PtrW'(i) - rptr_q;
    assign entry_valid_o[i]                     = (CntW'(off) < cnt_q);
    assign entry_waddr_o[i*RfAddrW +: RfAddrW]  = waddr_q[i];
  end

endmodule

// File: rtl/ibex_rf_wport_sched.sv
// rtl/ibex_rf_wport_sched.sv - arbitrates the single RF write port between LSU, ID/EX and aux
module ibex_rf_wport_sched import ibex_pkg::*; #(
  parameter int Depth   = 2,
  parameter int MaxWait = 4
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         setback_i,
  input  logic         lsu_we_i,
  input  logic [4:0]   lsu_waddr_i,
  input  logic [31:0]  lsu_wdata_i,
  input  logic         id_valid_i,
  input  logic [4:0]   id_waddr_i,
  input  logic [31:0]  id_wdata_i,
  output logic         id_ready_o,
  input  logic         aux_valid_i,
  input  logic [4:0]   aux_waddr_i,
  input  logic [31:0]  aux_wdata_i,
  output logic         aux_ready_o,
  input  logic [4:0]   rs1_addr_i,
  input  logic [4:0]   rs2_addr_i,
  output logic         aux_hazard_o,
  output logic         aux_pending_o,
  output logic         rf_we_o,
  output logic [4:0]   rf_waddr_o,
  output logic [31:0]  rf_wdata_o,
  output logic [1:0]   rf_src_o
);

  localparam int AgeW = 4;

  logic [RfAddrW-1:0]       head_waddr;
  logic [31:0]              head_wdata;
  logic                     fifo_full, fifo_empty, head_valid, push;
  logic [Depth-1:0]         entry_valid;
  logic [Depth*RfAddrW-1:0] entry_waddr;
  logic [AgeW-1:0]          age_q;
  logic                     aux_urgent, grant_lsu, grant_id, grant_aux;
  wport_src_e               src;

  assign head_valid  = ~fifo_empty;
  assign aux_urgent  = head_valid & (age_q == AgeW'(MaxWait));
  assign aux_ready_o = ~fifo_full;
  assign push        = aux_valid_i & aux_ready_o;

  // Setback mutes everything except LSU, whose data is already committed.
  assign grant_lsu = lsu_we_i;
  assign grant_aux = ~lsu_we_i & ~setback_i & head_valid & (aux_urgent | ~id_valid_i);
  assign grant_id  = ~lsu_we_i & ~setback_i & ~aux_urgent & id_valid_i;

  assign id_ready_o    = id_valid_i & grant_id;
  assign aux_pending_o = head_valid;

  always_comb begin
    src        = WPORT_NONE;
    rf_waddr_o = '0;
    rf_wdata_o = '0;
    if (grant_lsu) begin
      src        = WPORT_LSU;
      rf_waddr_o = lsu_waddr_i;
      rf_wdata_o = lsu_wdata_i;
    end else if (grant_id) begin
      src        = WPORT_ID;
      rf_waddr_o = id_waddr_i;
      rf_wdata_o = id_wdata_i;
    end else if (grant_aux) begin
      src        = WPORT_AUX;
      rf_waddr_o = head_waddr;
      rf_wdata_o = head_wdata;
    end
  end

  assign rf_src_o = src;
  assign rf_we_o  = (src != WPORT_NONE) && (rf_waddr_o != '0);

  always_comb begin
    aux_hazard_o = 1'b0;
    for (int i = 0; i < Depth; i++) begin
      if (entry_valid[i] && entry_waddr[i*RfAddrW +: RfAddrW] != '0 &&
          (entry_waddr[i*RfAddrW +: RfAddrW] == rs1_addr_i ||
           entry_waddr[i*RfAddrW +: RfAddrW] == rs2_addr_i)) begin
        aux_hazard_o = 1'b1;
      end
    end
    if (push && aux_waddr_i != '0 && (aux_waddr_i == rs1_addr_i || aux_waddr_i == rs2_addr_i)) begin
      aux_hazard_o = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      age_q <= '0;
    end else if (setback_i || grant_aux || !head_valid) begin
      age_q <= '0;
    end else if (age_q != AgeW'(MaxWait)) begin
      age_q <= age_q + 1'b1;
    end
  end

  ibex_rf_wport_fifo #(
    .Depth (Depth),
    .DataW (32)
  ) u_fifo (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .flush_i       (setback_i),
    .push_i        (push),
    .push_waddr_i  (aux_waddr_i),
    .push_wdata_i  (aux_wdata_i),
    .pop_i         (grant_aux),
    .head_waddr_o  (head_waddr),
    .head_wdata_o  (head_wdata),
    .full_o        (fifo_full),
    .empty_o       (fifo_empty),
    .entry_valid_o (entry_valid),
    .entry_waddr_o (entry_waddr)
  );

  a_one_grant: assert property (@(posedge clk_i) disable iff (!rst_ni)
    $onehot0({grant_lsu, grant_id, grant_aux}));

endmodule
